// File: rtl/result_reader.sv
// Readback engine: reads the four result banks in lockstep, packs each address into one
// 32-bit word and streams it to the host through a small credit-protected output FIFO.
module result_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [DATA_W-1:0]     ram_q0,
    input  logic [DATA_W-1:0]     ram_q1,
    input  logic [DATA_W-1:0]     ram_q2,
    input  logic [DATA_W-1:0]     ram_q3,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [4*DATA_W-1:0]   readdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]          state;
    logic [ADDR_W:0]     remaining;
    logic [ADDR_W-1:0]   next_addr;
    logic                vld_p1;
    logic [4*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    pending;
    logic                pop;
    logic                credit;

    assign pop      = rd_valid && rd_ready;
    assign rd_valid = (fifo_count != '0);
    assign readdata = rd_valid ? mem[rd_ptr] : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);

    // Words already queued plus reads still in the RAM pipeline; a new read is only
    // issued when that total leaves a guaranteed FIFO slot for its return.
    assign pending = fifo_count + CNT_W'(ram_rd_en) + CNT_W'(vld_p1);
    assign credit  = (pending < CNT_W'(FIFO_DEPTH));

    // Stage p0: command FSM and read issue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            next_addr <= '0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
        end else begin
            ram_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            state     <= READ;
                            remaining <= word_count;
                            next_addr <= base_addr;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                READ: begin
                    if (credit) begin
                        ram_rd_en <= 1'b1;
                        ram_addr  <= next_addr;
                        next_addr <= next_addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!ram_rd_en && !vld_p1 &&
                        fifo_count == (pop ? CNT_W'(1) : CNT_W'(0)))
                        state <= FIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: RAM data is valid this cycle; control tracking for the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            vld_p1 <= ram_rd_en;
            if (vld_p1)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({vld_p1, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1)
            mem[wr_ptr] <= {ram_q0, ram_q1, ram_q2, ram_q3};
    end

endmodule
